// File: rtl/puf_pkg.sv
// Shared definitions for the ring-oscillator PUF measurement controller.
// Contents:
//   meas_state_e  - measurement sequencer states
//   DEF_*         - default parameter values for puf_meas_ctrl
//   timer_width() - width needed by the shared state timer
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    WAIT_DONE,
    COMPARE,
    DONE,
    ERR
  } meas_state_e;

  localparam int DEF_CNT_W          = 32;
  localparam int DEF_NUM_BITS       = 8;
  localparam int DEF_CLR_CYCLES     = 4;
  localparam int DEF_GATE_CYCLES    = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // The one timer serves both the gate window and the timeouts, so it must
  // be able to hold whichever of the two limits is larger.
  function automatic int timer_width(input int gate_cycles, input int timeout_cycles);
    int max_cycles;
    max_cycles = (gate_cycles > timeout_cycles) ? gate_cycles : timeout_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/puf_sync2.sv
// Two-flop synchronizer that brings a level signal from a ring-oscillator
// clock domain into the system clock domain.
// Ports:
//   clk - system clock
//   rst - synchronous active-low reset; clears both flops
//   d   - asynchronous level input
//   q   - synchronized level output (two clk cycles of latency)
module puf_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // The first flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/puf_meas_ctrl.sv
// Initiator side of a ring-oscillator counter pair. For each of NUM_BITS RO
// pairs it clears both counters, opens a fixed gate window, waits for both
// counters to report done, and records whether counter A beat counter B.
// The assembled response word is returned through a valid/ready handshake.
// Ports:
//   clk, rst              - system clock, synchronous active-low reset
//   start                 - request a full measurement (honoured only in IDLE)
//   busy                  - high whenever the sequencer is not idle
//   pair_sel              - RO pair currently routed to counters A/B
//   ro_en                 - enables the selected ring oscillators
//   cnt_clear, cnt_ctrl   - clear and count-enable to both counters
//   cnt_done_a/b          - counter done levels (RO domains, synchronized here)
//   cnt_a, cnt_b          - counter values, frozen while done is high
//   resp, resp_valid      - response word and its valid flag
//   resp_ready            - consumer accepts resp
//   err_timeout           - sticky timeout flag, cleared by the next start
module puf_meas_ctrl
  import puf_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int NUM_BITS       = DEF_NUM_BITS,
  parameter int CLR_CYCLES     = DEF_CLR_CYCLES,
  parameter int GATE_CYCLES    = DEF_GATE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic [$clog2(NUM_BITS)-1:0] pair_sel,
  output logic                        ro_en,
  output logic                        cnt_clear,
  output logic                        cnt_ctrl,
  input  logic                        cnt_done_a,
  input  logic                        cnt_done_b,
  input  logic [CNT_W-1:0]            cnt_a,
  input  logic [CNT_W-1:0]            cnt_b,
  output logic [NUM_BITS-1:0]         resp,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic                        err_timeout
);

  localparam int SEL_W = $clog2(NUM_BITS);
  localparam int TMR_W = timer_width(GATE_CYCLES, TIMEOUT_CYCLES);

  // The timer reads 0 in the first cycle of a state, so "N cycles have
  // elapsed" is reached when it shows N-1.
  localparam logic [TMR_W-1:0] CLR_LAST     = TMR_W'(CLR_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST    = TMR_W'(GATE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SEL_W-1:0] PAIR_LAST    = SEL_W'(NUM_BITS - 1);

  meas_state_e      state;
  meas_state_e      state_next;
  logic [TMR_W-1:0] timer;
  logic             done_a_s;
  logic             done_b_s;

  puf_sync2 u_sync_a (
    .clk (clk),
    .rst (rst),
    .d   (cnt_done_a),
    .q   (done_a_s)
  );

  puf_sync2 u_sync_b (
    .clk (clk),
    .rst (rst),
    .d   (cnt_done_b),
    .q   (done_b_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and counter-control decode. Leaving CLEAR requires both
  // synchronized done levels to be low, which proves the clear actually
  // reached both RO domains rather than trusting a stale done.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    ro_en      = 1'b0;
    cnt_clear  = 1'b0;
    cnt_ctrl   = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        cnt_clear = 1'b1;
        ro_en     = 1'b1;
        if (timer >= CLR_LAST && !done_a_s && !done_b_s) begin
          state_next = GATE;
        end else if (timer >= TIMEOUT_LAST) begin
          state_next = ERR;
        end
      end
      GATE: begin
        cnt_ctrl = 1'b1;
        ro_en    = 1'b1;
        if (timer == GATE_LAST) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        ro_en = 1'b1;
        if (done_a_s && done_b_s) begin
          state_next = COMPARE;
        end else if (timer >= TIMEOUT_LAST) begin
          state_next = ERR;
        end
      end
      COMPARE: begin
        ro_en      = 1'b1;
        state_next = (pair_sel == PAIR_LAST) ? DONE : CLEAR;
      end
      DONE: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      ERR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Shared cycle timer: restarts from zero on every state change and
  // saturates so a long stay in IDLE or DONE cannot wrap it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timer <= '0;
    end else if (state_next != state) begin
      timer <= '0;
    end else if (timer != '1) begin
      timer <= timer + 1'b1;
    end
  end

  // Pair index, response bits and the sticky timeout flag. The counter
  // values are only looked at in COMPARE, when both counters are frozen,
  // so they need no synchronization. An aborted run keeps its partial bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pair_sel    <= '0;
      resp        <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pair_sel    <= '0;
            err_timeout <= 1'b0;
          end
        end
        COMPARE: begin
          resp[pair_sel] <= (cnt_a > cnt_b);
          if (pair_sel != PAIR_LAST) begin
            pair_sel <= pair_sel + 1'b1;
          end
        end
        ERR: begin
          err_timeout <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_meas_ctrl.sv
// Self-checking bench for puf_meas_ctrl. Two behavioural counters run on a
// separate RO clock; per-pair final counts come from tables filled with
// $urandom, and the expected response is derived from those tables.
`timescale 1ns/1ps
module tb_puf_meas_ctrl;

  localparam int CNT_W          = 32;
  localparam int NUM_BITS       = 4;
  localparam int CLR_CYCLES     = 4;
  localparam int GATE_CYCLES    = 16;
  localparam int TIMEOUT_CYCLES = 64;
  localparam int SEL_W          = $clog2(NUM_BITS);

  logic                clk = 1'b0;
  logic                ro_clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                busy;
  logic [SEL_W-1:0]    pair_sel;
  logic                ro_en;
  logic                cnt_clear;
  logic                cnt_ctrl;
  logic                cnt_done_a;
  logic                cnt_done_b;
  logic [CNT_W-1:0]    cnt_a;
  logic [CNT_W-1:0]    cnt_b;
  logic [NUM_BITS-1:0] resp;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic                err_timeout;

  logic [CNT_W-1:0] tbl_a [NUM_BITS];
  logic [CNT_W-1:0] tbl_b [NUM_BITS];
  logic done_a_m;
  logic done_b_m;
  bit   stuck_a;
  bit   hold_b_low;
  bit   counted;
  int   ro_delay;

  int tests_run;
  int failures;

  int gate_lens[$];
  int gate_sel[$];
  int clear_lens[$];
  int quiet_len;
  bit valid_seen;

  always #5 clk = ~clk;
  always #6.5 ro_clk = ~ro_clk;

  assign cnt_done_a = stuck_a ? 1'b1 : done_a_m;
  assign cnt_done_b = hold_b_low ? 1'b0 : done_b_m;

  puf_meas_ctrl #(
    .CNT_W          (CNT_W),
    .NUM_BITS       (NUM_BITS),
    .CLR_CYCLES     (CLR_CYCLES),
    .GATE_CYCLES    (GATE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .pair_sel    (pair_sel),
    .ro_en       (ro_en),
    .cnt_clear   (cnt_clear),
    .cnt_ctrl    (cnt_ctrl),
    .cnt_done_a  (cnt_done_a),
    .cnt_done_b  (cnt_done_b),
    .cnt_a       (cnt_a),
    .cnt_b       (cnt_b),
    .resp        (resp),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .err_timeout (err_timeout)
  );

  // Behavioural counter pair in the RO domain: clear drops done, the gate
  // makes the value churn, and some RO cycles after the gate closes the
  // table value for the selected pair is frozen and done rises.
  initial begin
    done_a_m = 1'b0;
    done_b_m = 1'b0;
    cnt_a    = '0;
    cnt_b    = '0;
    counted  = 1'b0;
    ro_delay = 0;
    forever begin
      @(posedge ro_clk);
      if (cnt_clear) begin
        done_a_m = 1'b0;
        done_b_m = 1'b0;
        counted  = 1'b0;
        cnt_a    = '0;
        cnt_b    = '0;
      end else if (cnt_ctrl) begin
        counted  = 1'b1;
        cnt_a    = $urandom;
        cnt_b    = $urandom;
        ro_delay = $urandom_range(0, 3);
      end else if (counted && !done_a_m) begin
        if (ro_delay > 0) begin
          ro_delay = ro_delay - 1;
        end else begin
          cnt_a    = tbl_a[pair_sel];
          cnt_b    = tbl_b[pair_sel];
          done_a_m = 1'b1;
          done_b_m = 1'b1;
        end
      end
    end
  end

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Bit i is set exactly when pair i's A count strictly exceeds its B count.
  function automatic logic [NUM_BITS-1:0] model_resp();
    logic [NUM_BITS-1:0] r;
    longint diff;
    for (int i = 0; i < NUM_BITS; i++) begin
      diff = longint'(tbl_b[i]) - longint'(tbl_a[i]);
      r[i] = (diff < 0);
    end
    return r;
  endfunction

  task automatic randomize_tables();
    for (int i = 0; i < NUM_BITS; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          tbl_a[i] = $urandom;
          tbl_b[i] = tbl_a[i];
        end
        1: begin
          tbl_a[i] = $urandom_range(0, 1000);
          tbl_b[i] = $urandom_range(0, 1000);
        end
        default: begin
          tbl_a[i] = $urandom;
          tbl_b[i] = $urandom;
        end
      endcase
    end
  endtask

  task automatic apply_stimulus();
    @(negedge clk);
    start = 1'b1;
  endtask

  // Follows one run cycle by cycle, recording gate/clear window lengths,
  // until the response is offered or the sequencer goes idle.
  task automatic wait_end(input int budget, output bit ended);
    int g;
    int c;
    g = 0;
    c = 0;
    ended = 1'b0;
    gate_lens.delete();
    gate_sel.delete();
    clear_lens.delete();
    quiet_len = 0;
    valid_seen = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (cnt_ctrl) begin
        if (g == 0) gate_sel.push_back(int'(pair_sel));
        g++;
      end else if (g > 0) begin
        gate_lens.push_back(g);
        g = 0;
      end
      if (cnt_clear) begin
        c++;
      end else if (c > 0) begin
        clear_lens.push_back(c);
        c = 0;
      end
      if (resp_valid) valid_seen = 1'b1;
      if (busy && !cnt_clear && !cnt_ctrl && !resp_valid) quiet_len++;
      if (resp_valid || !busy) begin
        ended = 1'b1;
        break;
      end
    end
    if (!ended) check_output("wait_budget", 64'd0, 64'd1);
  endtask

  task automatic finish_handshake(input string tag, input logic [NUM_BITS-1:0] exp,
                                  input int hold, input bit poke, input bit simul);
    for (int n = 0; n < hold; n++) begin
      @(negedge clk);
      start = (poke && n == hold / 2);
      check_output({tag, "_hold"}, {resp_valid, busy, resp}, {2'b11, exp});
    end
    @(negedge clk);
    start      = simul;
    resp_ready = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    resp_ready = 1'b0;
    check_output({tag, "_release"}, {busy, resp_valid}, 2'b00);
    @(negedge clk);
    check_output({tag, "_no_restart"}, busy, 1'b0);
  endtask

  task automatic normal_run(input string tag, input int hold, input bit poke, input bit simul,
                            output logic [NUM_BITS-1:0] exp);
    bit ended;
    int bad_gate;
    int min_clr;
    exp = model_resp();
    apply_stimulus();
    wait_end(2000, ended);
    check_output({tag, "_ended"}, ended, 1'b1);
    check_output({tag, "_valid"}, resp_valid, 1'b1);
    check_output({tag, "_resp"}, resp, exp);
    check_output({tag, "_err"}, err_timeout, 1'b0);
    check_output({tag, "_busy_ro"}, {busy, ro_en}, 2'b10);
    check_output({tag, "_pairs"}, gate_lens.size(), NUM_BITS);
    bad_gate = 0;
    foreach (gate_lens[i]) begin
      if (gate_lens[i] != GATE_CYCLES || gate_sel[i] != i) bad_gate++;
    end
    check_output({tag, "_gate_windows"}, bad_gate, 0);
    check_output({tag, "_clears"}, clear_lens.size(), NUM_BITS);
    min_clr = 1 << 30;
    foreach (clear_lens[i]) begin
      if (clear_lens[i] < min_clr) min_clr = clear_lens[i];
    end
    check_output({tag, "_clear_min"}, min_clr >= CLR_CYCLES, 1'b1);
    finish_handshake(tag, exp, hold, poke, simul);
  endtask

  task automatic error_run(input string tag, input bit in_clear, input logic [NUM_BITS-1:0] prev);
    bit ended;
    apply_stimulus();
    wait_end(2000, ended);
    check_output({tag, "_ended"}, ended, 1'b1);
    check_output({tag, "_valid_seen"}, valid_seen, 1'b0);
    check_output({tag, "_err"}, err_timeout, 1'b1);
    check_output({tag, "_idle_outs"}, {busy, cnt_ctrl, ro_en, resp_valid}, 4'b0000);
    check_output({tag, "_resp_kept"}, resp, prev);
    if (in_clear) begin
      check_output({tag, "_no_gate"}, gate_lens.size(), 0);
      check_output({tag, "_clear_len"}, (clear_lens.size() > 0) ? clear_lens[0] : -1,
                   TIMEOUT_CYCLES);
    end else begin
      check_output({tag, "_gate_len"}, (gate_lens.size() == 1) ? gate_lens[0] : -1, GATE_CYCLES);
      check_output({tag, "_wait_len"}, quiet_len, TIMEOUT_CYCLES + 1);
    end
  endtask

  initial begin
    logic [NUM_BITS-1:0] last;
    bit reached;
    tests_run = 0;
    failures  = 0;
    stuck_a    = 1'b0;
    hold_b_low = 1'b0;
    for (int i = 0; i < NUM_BITS; i++) begin
      tbl_a[i] = '0;
      tbl_b[i] = '0;
    end

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ctrl", {busy, ro_en, cnt_clear, cnt_ctrl, resp_valid, err_timeout}, 6'b0);
    check_output("reset_pair_sel", pair_sel, 0);
    check_output("reset_resp", resp, 0);
    @(negedge clk);
    rst = 1'b1;

    // Pairs 0 and 2 win, pair 1 ties at 100, pair 3 loses.
    tbl_a[0] = 200; tbl_b[0] = 100;
    tbl_a[1] = 100; tbl_b[1] = 100;
    tbl_a[2] = 300; tbl_b[2] = 50;
    tbl_a[3] = 5;   tbl_b[3] = 900;
    normal_run("directed", 50, 1'b1, 1'b0, last);
    check_output("directed_word", last, 4'b0101);

    hold_b_low = 1'b1;
    error_run("stuck_done_b", 1'b0, last);
    hold_b_low = 1'b0;

    randomize_tables();
    normal_run("after_err", 3, 1'b0, 1'b1, last);

    stuck_a = 1'b1;
    error_run("stale_done_a", 1'b1, last);
    stuck_a = 1'b0;

    randomize_tables();
    apply_stimulus();
    reached = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (cnt_ctrl && pair_sel == SEL_W'(2)) begin
        reached = 1'b1;
        break;
      end
    end
    check_output("rst_reach_gate", reached, 1'b1);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("rst_mid_ctrl", {cnt_ctrl, cnt_clear, busy, ro_en, resp_valid, err_timeout}, 6'b0);
    check_output("rst_mid_pair_sel", pair_sel, 0);
    check_output("rst_mid_resp", resp, 0);
    @(negedge clk);
    rst = 1'b1;
    randomize_tables();
    normal_run("post_rst", 2, 1'b0, 1'b0, last);

    for (int r = 0; r < 5; r++) begin
      randomize_tables();
      normal_run($sformatf("rand%0d", r), $urandom_range(0, 6), 1'b0, 1'($urandom_range(0, 1)), last);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
